lane_map_arb: RTL and testbench
===============================

LANE_MAP_ARB -- requirements
Module: lane_map_arb

Interface
REQ-001 Parameter WIDTH, default 4, lane word width in bits; legal values 1..32.
REQ-002 Parameter NREQ, default 4, number of requesters; legal values 2..8.
REQ-003 Parameter MAXBURST, default 4, maximum consecutive words granted to one owner; legal values 1..15.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  NREQ  per-requester word-valid.
REQ-007 req_data  input  NREQ*WIDTH  requester k word in bits [k*WIDTH +: WIDTH].
REQ-008 req_ready  output  NREQ  per-requester accept; at most one bit set.
REQ-009 out_valid  output  1  output register holds a word.
REQ-010 out_ready  input  1  downstream accept.
REQ-011 out_data  output  WIDTH  registered word, bit order unchanged from the input.
REQ-012 out_and  output  1  registered reduction-AND of out_data.
REQ-013 out_id  output  max(1,$clog2(NREQ))  index of the requester that supplied out_data.

Function
REQ-014 A transfer on requester k SHALL occur when req_valid[k] and req_ready[k] are both 1 in the same cycle.
REQ-015 An output transfer SHALL occur when out_valid and out_ready are both 1 in the same cycle.
REQ-016 The output stage SHALL be a single register; the block SHALL be able to load it when out_valid=0, or when out_valid=1 and out_ready=1.
REQ-017 req_ready SHALL be combinational from state, req_valid and out_ready, and SHALL be 0 for all requesters when the output register cannot load.
REQ-018 An input transfer on requester k SHALL load out_data=req_data[k], out_and=&req_data[k] and out_id=k at the next edge, with out_valid=1 and one cycle of latency.
REQ-019 An output transfer with no simultaneous input transfer SHALL clear out_valid; a simultaneous input transfer SHALL keep out_valid=1 with the new word, with no bubble.
REQ-020 The arbitration FSM SHALL have two states: IDLE (no owner) and OWN (owner register holds an index).
REQ-021 IDLE: the next owner SHALL be the first requester with req_valid=1, searching upward from (last_owner+1) mod NREQ and wrapping.
REQ-022 The owner selected in IDLE SHALL be granted in the same cycle; on its transfer the FSM SHALL enter OWN with burst count=1.
REQ-023 OWN: only the owner SHALL be granted; each owner transfer SHALL increment the burst count.
REQ-024 OWN SHALL exit to IDLE when the owner drops req_valid, or on the transfer that brings the burst count to MAXBURST.
REQ-025 On exit from OWN, last_owner SHALL be set to the owner, so the next arbitration starts one position past it.
REQ-026 A cycle in OWN where the owner's req_valid=0 SHALL produce no transfer, with the exit to IDLE at the next edge.
REQ-027 The burst count SHALL not be incremented by a stalled cycle (owner valid but the output register cannot load).
REQ-028 While stalled, req_ready SHALL be all-zero and no state change other than the output register update SHALL occur.
REQ-029 req_data of non-granted requesters SHALL not affect any output.

Reset
REQ-030 While rst_n=0, the following SHALL hold immediately, without waiting for a clock edge: out_valid=0, out_data=0, out_and=0, out_id=0, FSM=IDLE, burst count=0, last_owner=NREQ-1.
REQ-031 req_ready SHALL be all-zero while rst_n=0.
REQ-032 Assertion of rst_n mid-burst SHALL discard the held word and ownership.
REQ-033 After release of rst_n, the first grant SHALL search from requester 0.

Verification
REQ-034 Scenario: reset, then req_valid=4'b0001 with data 4'hF and out_ready=1 -> req_ready=4'b0001; next cycle out_valid=1, out_data=4'hF, out_and=1, out_id=0.
REQ-035 Scenario: all four requesters continuously valid, MAXBURST=4, out_ready=1 -> out_id sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0 with no idle cycles.
REQ-036 Scenario: owner 2 drops valid after 2 words while requester 1 is valid -> the next grant goes to requester 3 if it is valid, else wraps to 1.
REQ-037 Scenario: out_ready=0 for 3 cycles with out_valid=1 -> req_ready=0, out_data stable, burst count unchanged; on release the word drains and the next word loads in the same cycle.
REQ-038 Scenario: rst_n pulled low while out_valid=1 in OWN -> out_valid=0 immediately; after release, requesters 3 and 0 both valid -> requester 0 wins.
REQ-039 Scenario: data 4'hE from requester 1 -> out_and=0; data 4'hF -> out_and=1.

Source files
------------

// File: rtl/lane_map_arb.sv
// Multi-requester lane arbiter: rotating-priority burst ownership feeding a
// single registered output word with its reduction-AND and source index.
module lane_map_arb #(
  parameter int WIDTH    = 4,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4,
  localparam int IDW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_and,
  output logic [IDW-1:0]        out_id
);

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   owner, owner_n;
  logic [IDW-1:0]   last, last_n;
  logic [3:0]       cnt, cnt_n;
  logic [IDW-1:0]   pick, idx, sel;
  logic             pick_any;
  logic             can_load;
  logic             xfer;
  logic             own_valid;
  logic             last_word;
  logic [NREQ-1:0]  grant;
  logic [WIDTH-1:0] word;

  assign can_load  = !out_valid || out_ready;
  assign own_valid = req_valid[owner];
  assign last_word = (cnt == 4'(MAXBURST - 1));

  // Rotating search: scan downward so the nearest one past last wins.
  always_comb begin
    pick     = '0;
    pick_any = 1'b0;
    idx      = '0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = IDW'((int'(last) + i) % NREQ);
      if (req_valid[idx]) begin
        pick     = idx;
        pick_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= IDW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (MAXBURST == 1) begin
            last_n = pick;
          end else begin
            state_n = OWN;
            owner_n = pick;
            cnt_n   = 4'd1;
          end
        end
      end
      OWN: begin
        if (!own_valid) begin
          state_n = IDLE;
          last_n  = owner;
          cnt_n   = '0;
        end else if (can_load) begin
          if (last_word) begin
            state_n = IDLE;
            last_n  = owner;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
    endcase
  end

  always_comb begin
    grant = '0;
    unique case (1'b1)
      (state == IDLE): if (can_load && pick_any) grant[pick] = 1'b1;
      (state == OWN):  if (can_load && own_valid) grant[owner] = 1'b1;
    endcase
  end

  assign sel       = (state == OWN) ? owner : pick;
  assign xfer      = |grant;
  assign req_ready = rst_n ? grant : '0;
  assign word      = req_data[int'(sel)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_and   <= 1'b0;
      out_id    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= word;
      out_and   <= &word;
      out_id    <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lane_map_arb.sv
// Bench for lane_map_arb: vector table, directed corner sequences and
// randomized traffic against a session-level reference model.
module tb_lane_map_arb;

  localparam int W  = 4;
  localparam int N  = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_and;
  logic [1:0]    out_id;

  lane_map_arb #(.WIDTH(W), .NREQ(N), .MAXBURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_and(out_and), .out_id(out_id)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a session has an owner (-1 when none) and a remaining quota.
  int         m_owner, m_last, m_left;
  logic       m_ov, m_and;
  logic [W-1:0] m_od;
  int         m_id;
  logic [N-1:0] last_ready;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_left  = 0;
    m_ov    = 0;
    m_od    = '0;
    m_and   = 0;
    m_id    = 0;
  endtask

  function automatic logic [N-1:0] model_grant(logic [N-1:0] v, logic r);
    logic [N-1:0] g;
    int k;
    g = '0;
    if (m_ov && !r) return g;
    if (m_owner >= 0) begin
      if (v[m_owner]) g[m_owner] = 1'b1;
      return g;
    end
    for (int i = 1; i <= N; i++) begin
      k = (m_last + i) % N;
      if (v[k]) begin
        g[k] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic model_update(input logic [N-1:0] v, input logic [N*W-1:0] d,
                              input logic r, input logic [N-1:0] g);
    int gi;
    gi = -1;
    for (int k = 0; k < N; k++) if (g[k]) gi = k;
    if (m_owner >= 0 && !v[m_owner]) begin
      m_last  = m_owner;
      m_owner = -1;
    end else if (gi >= 0) begin
      if (m_owner < 0) begin
        m_owner = gi;
        m_left  = MB;
      end
      m_left--;
      if (m_left == 0) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
    if (gi >= 0) begin
      m_ov  = 1;
      m_od  = d[gi*W +: W];
      m_and = &m_od;
      m_id  = gi;
    end else if (r) begin
      m_ov = 0;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d,
                      input logic r);
    logic [N-1:0] g;
    req_valid = v;
    req_data  = d;
    out_ready = r;
    g = model_grant(v, r);
    @(negedge clk);
    last_ready = req_ready;
    chk("model_ready", int'(req_ready), int'(g));
    @(posedge clk);
    model_update(v, d, r, g);
    #1;
    chk("model_ov", int'(out_valid), int'(m_ov));
    if (m_ov) begin
      chk("model_data", int'(out_data), int'(m_od));
      chk("model_and", int'(out_and), int'(m_and));
      chk("model_id", int'(out_id), m_id);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_and", int'(out_and), 0);
    chk("rst_id", int'(out_id), 0);
    chk("rst_ready", int'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_hold", int'(req_ready), 0);
    rst_n = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]   v;
    logic [N*W-1:0] d;
    logic           r;
    logic [N-1:0]   rdy;
    logic           ov;
    logic [W-1:0]   od;
    logic           oa;
    int             id;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] held;
    tbl[0] = '{4'b0001, 16'h000F, 1'b1, 4'b0001, 1'b1, 4'hF, 1'b1, 0};
    tbl[1] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 0};
    tbl[2] = '{4'b0010, 16'h00E0, 1'b1, 4'b0010, 1'b1, 4'hE, 1'b0, 1};
    tbl[3] = '{4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 0};
    tbl[4] = '{4'b1001, 16'h7005, 1'b1, 4'b1000, 1'b1, 4'h7, 1'b0, 3};
    tbl[5] = '{4'b1001, 16'hF005, 1'b1, 4'b1000, 1'b1, 4'hF, 1'b1, 3};
    tbl[6] = '{4'b0001, 16'hA003, 1'b1, 4'b0000, 1'b0, 4'h0, 1'b0, 0};
    tbl[7] = '{4'b0001, 16'hA003, 1'b1, 4'b0001, 1'b1, 4'h3, 1'b0, 0};

    #2;
    do_reset();

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r);
      chk($sformatf("vec%0d_ready", i), int'(last_ready), int'(tbl[i].rdy));
      chk($sformatf("vec%0d_ov", i), int'(out_valid), int'(tbl[i].ov));
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d_data", i), int'(out_data), int'(tbl[i].od));
        chk($sformatf("vec%0d_and", i), int'(out_and), int'(tbl[i].oa));
        chk($sformatf("vec%0d_id", i), int'(out_id), tbl[i].id);
      end
    end

    // Full rotation with every requester busy: bursts of MB, no bubbles.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      step(4'b1111, 16'h1234, 1'b1);
      chk("rot_ov", int'(out_valid), 1);
      chk($sformatf("rot_id%0d", i), int'(out_id), (i / MB) % N);
    end

    // Owner 2 drops after two words; next grant goes to 3, else wraps to 1.
    do_reset();
    step(4'b0100, 16'h0500, 1'b1);
    step(4'b0110, 16'h0600, 1'b1);
    step(4'b0010, 16'h0000, 1'b1);
    chk("drop_noxfer", int'(last_ready), 0);
    step(4'b1010, 16'h9010, 1'b1);
    chk("drop_to3", int'(last_ready), 4'b1000);
    do_reset();
    step(4'b0100, 16'h0500, 1'b1);
    step(4'b0110, 16'h0600, 1'b1);
    step(4'b0010, 16'h0000, 1'b1);
    step(4'b0010, 16'h0010, 1'b1);
    chk("drop_wrap1", int'(last_ready), 4'b0010);

    // Stall for three cycles mid-burst: quota must not be consumed.
    do_reset();
    step(4'b0011, 16'h00C9, 1'b1);
    held = out_data;
    chk("stall_first", int'(held), 4'h9);
    for (int i = 0; i < 3; i++) begin
      step(4'b0011, 16'h0045 + 16'(i), 1'b0);
      chk("stall_ready", int'(last_ready), 0);
      chk("stall_hold", int'(out_data), int'(held));
    end
    step(4'b0011, 16'h0066, 1'b1);
    chk("stall_release", int'(last_ready), 4'b0001);
    chk("stall_newword", int'(out_data), 4'h6);
    step(4'b0011, 16'h0077, 1'b1);
    chk("stall_w3", int'(last_ready), 4'b0001);
    step(4'b0011, 16'h0088, 1'b1);
    chk("stall_w4", int'(last_ready), 4'b0001);
    step(4'b0011, 16'h00A8, 1'b1);
    chk("stall_handoff", int'(last_ready), 4'b0010);
    chk("stall_handoff_data", int'(out_data), 4'hA);

    // Reset mid-burst, then 3 and 0 compete: 0 wins.
    do_reset();
    step(4'b0100, 16'h0B00, 1'b1);
    step(4'b0100, 16'h0C00, 1'b1);
    chk("midrst_pre_ov", int'(out_valid), 1);
    req_valid = 4'b1111;
    do_reset();
    step(4'b1001, 16'h5003, 1'b1);
    chk("midrst_win0", int'(last_ready), 4'b0001);
    chk("midrst_id0", int'(out_id), 0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) v[k] = ($urandom_range(0, 9) < 7);
      step(v, 16'($urandom), ($urandom_range(0, 3) != 0));
      if (i == 300) begin
        req_valid = v;
        do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
